// File: rtl/pid_stat_fifo.sv
// First-word-fall-through token FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overrun/underrun flags.
module pid_stat_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int CNT_BITS  = 4,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                w_enable,
    input  logic [WIDTH-1:0]    w_data,
    input  logic                r_enable,
    output logic [WIDTH-1:0]    r_data,
    output logic                empty,
    output logic                full,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [CNT_BITS-1:0] count,
    output logic                overrun,
    output logic                underrun
);

    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [CNT_BITS-1:0] count_q;
    logic                rd_ok;
    logic                wr_ok;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + PTR_BITS'(1);
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_BITS'(DEPTH));
    assign almost_full  = (count_q >= CNT_BITS'(AF_THRESH));
    assign almost_empty = (count_q <= CNT_BITS'(AE_THRESH));
    assign count        = count_q;

    // A pop frees a slot in the same edge, so a full FIFO can still accept a write.
    assign rd_ok = r_enable && !empty;
    assign wr_ok = w_enable && (!full || rd_ok);

    assign r_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok && !clear) begin
            mem[wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (wr_ok && !rd_ok) begin
                count_q <= count_q + CNT_BITS'(1);
            end else if (rd_ok && !wr_ok) begin
                count_q <= count_q - CNT_BITS'(1);
            end
            if (w_enable && !wr_ok) begin
                overrun <= 1'b1;
            end
            if (r_enable && !rd_ok) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pid_stat_fifo.sv
// Self-checking bench for pid_stat_fifo: table of stimulus/expected records
// plus a data scoreboard, and a hand-written async reset sequence.
module tb_pid_stat_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CNT_BITS = 4;
    localparam int AF_THRESH = 6;
    localparam int AE_THRESH = 2;

    logic                clk = 1'b0;
    logic                n_rst;
    logic                clear;
    logic                w_enable;
    logic [WIDTH-1:0]    w_data;
    logic                r_enable;
    logic [WIDTH-1:0]    r_data;
    logic                empty;
    logic                full;
    logic                almost_full;
    logic                almost_empty;
    logic [CNT_BITS-1:0] count;
    logic                overrun;
    logic                underrun;

    pid_stat_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_BITS(CNT_BITS),
        .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
    ) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear),
        .w_enable(w_enable), .w_data(w_data), .r_enable(r_enable),
        .r_data(r_data), .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overrun(overrun), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       clr;
        int         cnt;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         pass_cnt = 0;
    int         total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic add(input logic we, input logic [7:0] wd, input logic re,
                       input logic clr, input int cnt, input logic ov, input logic un);
        vec_t v;
        v.we = we; v.wd = wd; v.re = re; v.clr = clr;
        v.cnt = cnt; v.ov = ov; v.un = un;
        vecs.push_back(v);
    endtask

    function automatic logic [5:0] flags_for(input int cnt, input logic ov, input logic un);
        return {cnt == 0, cnt == DEPTH, cnt >= AF_THRESH, cnt <= AE_THRESH, ov, un};
    endfunction

    // Head word on r_data is checked before the edge; state after it.
    task automatic apply(input vec_t v, input int idx);
        bit rd, wr;
        @(negedge clk);
        w_enable = v.we; w_data = v.wd; r_enable = v.re; clear = v.clr;
        #1;
        check($sformatf("r_data[%0d]", idx), {24'b0, r_data},
              (sb.size() > 0) ? {24'b0, sb[0]} : 32'h0);
        if (v.clr) begin
            sb.delete();
        end else begin
            rd = v.re && (sb.size() > 0);
            wr = v.we && ((sb.size() < DEPTH) || rd);
            if (rd) void'(sb.pop_front());
            if (wr) sb.push_back(v.wd);
        end
        @(posedge clk);
        #1;
        check($sformatf("count[%0d]", idx), {28'b0, count}, v.cnt);
        check($sformatf("flags[%0d]", idx),
              {26'b0, empty, full, almost_full, almost_empty, overrun, underrun},
              {26'b0, flags_for(v.cnt, v.ov, v.un)});
    endtask

    initial begin
        n_rst = 1'b0; clear = 1'b0; w_enable = 1'b0; w_data = '0; r_enable = 1'b0;

        // Test 1: three writes, then drain
        add(1, 8'hA1, 0, 0, 1, 0, 0);
        add(1, 8'hB2, 0, 0, 2, 0, 0);
        add(1, 8'hC3, 0, 0, 3, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 8'h00, 1, 0, 2 - i, 0, 0);
        // Test 2: fill, overrun on extra write
        for (int i = 0; i < 8; i++) add(1, 8'h10 + 8'(i), 0, 0, i + 1, 0, 0);
        add(1, 8'hFF, 0, 0, 8, 1, 0);
        // Test 3: simultaneous read/write while full, then drain across the wrap
        for (int i = 0; i < 3; i++) add(1, 8'h55, 1, 0, 8, 1, 0);
        for (int i = 0; i < 8; i++) add(0, 8'h00, 1, 0, 7 - i, 1, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0);
        // Test 4: read+write on empty
        add(1, 8'h3C, 1, 0, 1, 0, 1);
        add(0, 8'h00, 1, 0, 0, 0, 1);
        add(0, 8'h00, 1, 0, 0, 0, 1);
        // Test 5: count 5 with overrun, then clear with concurrent write
        for (int i = 0; i < 8; i++) add(1, 8'h20 + 8'(i), 0, 0, i + 1, 0, 1);
        add(1, 8'hEE, 0, 0, 8, 1, 1);
        for (int i = 0; i < 3; i++) add(0, 8'h00, 1, 0, 7 - i, 1, 1);
        add(1, 8'h99, 0, 1, 0, 0, 0);
        add(1, 8'h77, 1, 1, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0);

        #12;
        check("reset_count", {28'b0, count}, 32'd0);
        check("reset_flags", {26'b0, empty, full, almost_full, almost_empty, overrun, underrun},
              32'b100100);
        check("reset_r_data", {24'b0, r_data}, 32'h0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Test 6: async reset between edges at count 4
        for (int i = 0; i < 4; i++) begin
            vec_t v;
            v.we = 1; v.wd = 8'h40 + 8'(i); v.re = 0; v.clr = 0;
            v.cnt = i + 1; v.ov = 0; v.un = 0;
            apply(v, 100 + i);
        end
        @(negedge clk);
        w_enable = 1'b1; w_data = 8'h44;
        #2;
        n_rst = 1'b0;
        #1;
        check("async_count", {28'b0, count}, 32'd0);
        check("async_flags", {26'b0, empty, full, almost_full, almost_empty, overrun, underrun},
              32'b100100);
        check("async_r_data", {24'b0, r_data}, 32'h0);
        sb.delete();
        @(negedge clk);
        w_enable = 1'b0;
        n_rst = 1'b1;
        begin
            vec_t v;
            v.we = 1; v.wd = 8'h5A; v.re = 0; v.clr = 0; v.cnt = 1; v.ov = 0; v.un = 0;
            apply(v, 200);
            v.we = 0; v.re = 1; v.cnt = 0;
            apply(v, 201);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
